// File: rtl/nios2_dbg_mem_master_pkg.sv
// ---------------------------------------------------------------------------
// nios2_dbg_mem_master_pkg
//
// Shared definitions for the debug memory master: FSM state encoding, the
// bit positions of the fields carried in the 38-bit debug data word (jdo),
// the fill value returned on a bus timeout and the Avalon response codes.
// ---------------------------------------------------------------------------
package nios2_dbg_mem_master_pkg;

    // Transfer FSM. READ and WRITE each mean "a request is on the bus".
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Width of the debug data word delivered by the debug slave.
    localparam int JDO_W = 38;

    // jdo field positions. The write data field overlaps the error-clear
    // bit; which meaning applies depends on the strobe that qualifies jdo.
    localparam int JDO_RD_WR     = 35;
    localparam int JDO_CLR_ERR   = 34;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_ADDR_LSB  = 2;

    // Bus data width.
    localparam int DATA_W = 32;

    // Value reported in MonDReg when a transfer is abandoned on timeout.
    localparam logic [DATA_W-1:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

    // Avalon-MM response code for a successful transfer.
    localparam logic [1:0] AVM_RESP_OKAY = 2'b00;

    // Any response code other than OKAY is reported as an error.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != AVM_RESP_OKAY;
    endfunction

endpackage

// File: rtl/nios2_dbg_mem_master_timeout.sv
// ---------------------------------------------------------------------------
// nios2_dbg_mem_timeout
//
// Loadable down-counter used to abandon a bus transfer that the slave stalls
// for too long. The counter is loaded when a transfer starts and decrements
// once per stalled cycle; o_expired is high while the count is zero, and the
// count saturates there.
//
// Ports:
//   clk         in   clock
//   reset_n     in   asynchronous active-low reset (count -> 0)
//   i_load      in   load i_load_val (has priority over i_dec)
//   i_load_val  in   TO_W-bit reload value
//   i_dec       in   decrement by one (ignored once expired)
//   o_expired   out  count is zero
// ---------------------------------------------------------------------------
module nios2_dbg_mem_timeout #(
    parameter int TO_W = 11
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_load,
    input  logic [TO_W-1:0] i_load_val,
    input  logic            i_dec,
    output logic            o_expired
);

    logic [TO_W-1:0] r_count;

    // NOTE: clocked state is written with non-blocking assignments only, so
    // every register samples its inputs from before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && !o_expired) begin
            r_count <= r_count - TO_W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/nios2_dbg_mem_master.sv
// ---------------------------------------------------------------------------
// nios2_dbg_mem_master
//
// Executes JTAG debug memory commands as single-word Avalon-MM transfers.
// The debug slave presents a command word (jdo) qualified by one of three
// strobes; this block decodes it, runs one read or write on the bus, and
// reports the result back through MonDReg / monitor_ready / monitor_error.
//
//   strobe a : load word address, optional error clear, optional read
//   strobe b : read or write at the current address, then address + 1
//   poll     : optional error clear
//
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   jdo[37:0]                        command word
//   take_action_ocimem_a             address-phase strobe
//   take_action_ocimem_b             data-phase strobe
//   take_no_action_ocimem_a          poll strobe
//   MonDReg[31:0]                    last read data / echoed write data
//   monitor_ready                    last command complete
//   monitor_error                    sticky error flag
//   avm_address[ADDR_W+1:0]          byte address (word aligned)
//   avm_read, avm_write              transfer requests
//   avm_writedata[31:0]              write data
//   avm_byteenable[3:0]              always all lanes
//   avm_readdata[31:0]               read data, valid on the accept cycle
//   avm_waitrequest                  slave stall
//   avm_response[1:0]                transfer status
// ---------------------------------------------------------------------------
module nios2_dbg_mem_master
    import nios2_dbg_mem_master_pkg::*;
#(
    parameter int ADDR_W         = 30,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [JDO_W-1:0]    jdo,
    input  logic                take_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    input  logic                take_no_action_ocimem_a,

    output logic [DATA_W-1:0]   MonDReg,
    output logic                monitor_ready,
    output logic                monitor_error,

    output logic [ADDR_W+1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [3:0]          avm_byteenable,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest,
    input  logic [1:0]          avm_response
);

    // The counter is loaded with one less than the budget: it reaches zero
    // on the last permitted stalled cycle, and a stall there abandons.
    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_e              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_incr;       // current transfer came from strobe b
    logic [DATA_W-1:0]   r_mon_dreg;
    logic                r_ready;
    logic                r_error;

    // -----------------------------------------------------------------------
    // Command decode
    // -----------------------------------------------------------------------
    logic w_idle;
    logic w_busy;
    logic w_a_acc;
    logic w_b_acc;
    logic w_drop;
    logic w_start_rd;
    logic w_start_wr;
    logic w_start;
    logic w_done;
    logic w_timeout;
    logic w_to_expired;
    logic w_err_set;
    logic w_err_clr;
    state_e w_state_nxt;

    // jdo bits that carry no meaning for this block.
    logic [3:0] w_unused_jdo;
    assign w_unused_jdo = {jdo[JDO_W-1:JDO_W-2], jdo[JDO_ADDR_LSB-1:0]};

    assign w_idle = (r_state == ST_IDLE);
    assign w_busy = (r_state == ST_READ) || (r_state == ST_WRITE);

    // Strobe a takes priority; a simultaneous strobe b is silently ignored.
    assign w_a_acc = w_idle && take_action_ocimem_a;
    assign w_b_acc = w_idle && take_action_ocimem_b && !take_action_ocimem_a;

    // Any command strobe while a transfer is in flight is lost and flagged.
    assign w_drop  = !w_idle && (take_action_ocimem_a || take_action_ocimem_b);

    assign w_start_rd = (w_a_acc && jdo[JDO_RD_WR]) ||
                        (w_b_acc && !jdo[JDO_RD_WR]);
    assign w_start_wr = w_b_acc && jdo[JDO_RD_WR];
    assign w_start    = w_start_rd || w_start_wr;

    // The slave accepts on the first non-stalled request cycle; a stall on
    // the last cycle of the budget abandons the transfer instead.
    assign w_done    = w_busy && !avm_waitrequest;
    assign w_timeout = w_busy && avm_waitrequest && w_to_expired;

    // Error sources outrank a clear landing in the same cycle.
    assign w_err_set = w_drop || w_timeout ||
                       (w_done && resp_is_error(avm_response));
    assign w_err_clr = (w_a_acc && jdo[JDO_CLR_ERR]) ||
                       (take_no_action_ocimem_a && jdo[JDO_CLR_ERR]);

    // -----------------------------------------------------------------------
    // Stall timeout
    // -----------------------------------------------------------------------
    nios2_dbg_mem_timeout #(
        .TO_W (TO_W)
    ) u_timeout (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_start),
        .i_load_val (TO_RELOAD),
        .i_dec      (w_busy && avm_waitrequest),
        .o_expired  (w_to_expired)
    );

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: the hold value is assigned first so every path through the
        // case drives w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rd) begin
                    w_state_nxt = ST_READ;
                end else if (w_start_wr) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_READ, ST_WRITE: begin
                if (w_done || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Address and write data
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
            r_incr <= 1'b0;
        end else begin
            if (w_start) begin
                r_incr <= w_b_acc;
            end
            // Only completed data-phase transfers advance; the counter wraps.
            if (w_a_acc) begin
                r_addr <= jdo[ADDR_W+JDO_ADDR_LSB-1:JDO_ADDR_LSB];
            end else if (w_done && r_incr) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdata <= '0;
        end else if (w_start_wr) begin
            r_wdata <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
        end
    end

    // -----------------------------------------------------------------------
    // Result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mon_dreg <= '0;
            r_ready    <= 1'b0;
        end else begin
            if (w_done) begin
                r_mon_dreg <= (r_state == ST_READ) ? avm_readdata : r_wdata;
            end else if (w_timeout) begin
                r_mon_dreg <= TIMEOUT_FILL;
            end

            if (w_start) begin
                r_ready <= 1'b0;
            end else if (w_done || w_timeout) begin
                r_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_error <= 1'b0;
        end else if (w_err_set) begin
            r_error <= 1'b1;
        end else if (w_err_clr) begin
            r_error <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Requests decode straight from the state register so an asynchronous
    // reset removes them immediately.
    assign avm_read       = (r_state == ST_READ);
    assign avm_write      = (r_state == ST_WRITE);
    assign avm_address    = {r_addr, 2'b00};
    assign avm_writedata  = r_wdata;
    assign avm_byteenable = 4'hF;

    assign MonDReg        = r_mon_dreg;
    assign monitor_ready  = r_ready;
    assign monitor_error  = r_error;

endmodule

// File: tb/tb_nios2_dbg_mem_master.sv
// ---------------------------------------------------------------------------
// tb_nios2_dbg_mem_master
//
// Self-checking bench for nios2_dbg_mem_master. Expected bus transfers and
// expected MonDReg results are queued as commands are issued; a bus monitor
// and a result monitor pop and compare them as the design produces output.
// ---------------------------------------------------------------------------
module tb_nios2_dbg_mem_master;

    localparam int ADDR_W   = 30;
    localparam int TO_CYC   = 16;
    localparam int TO_W     = 5;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    logic              clk;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_a;
    logic              take_b;
    logic              take_p;
    logic [31:0]       mon_dreg;
    logic              mon_ready;
    logic              mon_error;
    logic [ADDR_W+1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;
    logic [1:0]        avm_response;

    // Slave model controls.
    int                slave_wait;
    int                wait_cnt;

    bus_t              exp_bus[$];
    logic [31:0]       exp_res[$];

    int                n_checks;
    int                n_errors;
    int                n_xfers;
    int                req_cycles;
    logic              prev_ready;

    nios2_dbg_mem_master #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TO_CYC),
        .TO_W           (TO_W)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_p),
        .MonDReg                 (mon_dreg),
        .monitor_ready           (mon_ready),
        .monitor_error           (mon_error),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_byteenable          (avm_byteenable),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest),
        .avm_response            (avm_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [37:0] jdo_a(input logic [29:0] waddr, input logic rd, input logic clr);
        return {2'b11, rd, clr, 2'b00, waddr, 2'b00};
    endfunction

    function automatic logic [37:0] jdo_bw(input logic [31:0] data);
        return {2'b00, 1'b1, data, 3'b000};
    endfunction

    function automatic logic [37:0] jdo_br();
        return {2'b00, 1'b0, 35'd0};
    endfunction

    function automatic logic [37:0] jdo_poll(input logic clr);
        return {3'b000, clr, 34'd0};
    endfunction

    // Present one command for one cycle; returns on the following negedge.
    task automatic drive(input logic a, input logic b, input logic p, input logic [37:0] d);
        @(negedge clk);
        jdo    = d;
        take_a = a;
        take_b = b;
        take_p = p;
        @(negedge clk);
        take_a = 1'b0;
        take_b = 1'b0;
        take_p = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (mon_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, mon_ready, 1);
    endtask

    // Slave: stalls each request for slave_wait cycles, then accepts.
    initial begin
        avm_waitrequest = 1'b0;
        avm_readdata    = '0;
        avm_response    = 2'b00;
        wait_cnt        = 0;
        forever begin
            @(posedge clk);
            #1;
            if (avm_read || avm_write) begin
                if (wait_cnt < slave_wait) begin
                    avm_waitrequest = 1'b1;
                    wait_cnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                end
            end else begin
                avm_waitrequest = 1'b0;
                wait_cnt        = 0;
            end
        end
    end

    // Bus monitor: every request cycle must match the head of the queue.
    initial begin
        n_xfers    = 0;
        req_cycles = 0;
        forever begin
            @(negedge clk);
            if (avm_read || avm_write) begin
                req_cycles++;
                check("bus_expected", exp_bus.size() != 0, 1);
                if (exp_bus.size() != 0) begin
                    check("bus_rd", avm_read, !exp_bus[0].wr);
                    check("bus_wr", avm_write, exp_bus[0].wr);
                    check("bus_addr", avm_address, exp_bus[0].addr);
                    if (exp_bus[0].wr) begin
                        check("bus_wdata", avm_writedata, exp_bus[0].data);
                    end
                    if (!avm_waitrequest) begin
                        void'(exp_bus.pop_front());
                        n_xfers++;
                    end
                end
            end
        end
    end

    // Result monitor: each rising monitor_ready delivers one result.
    initial begin
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_ready && !prev_ready) begin
                check("res_expected", exp_res.size() != 0, 1);
                if (exp_res.size() != 0) begin
                    check("mondreg", mon_dreg, exp_res.pop_front());
                end
            end
            prev_ready = mon_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        n_checks     = 0;
        n_errors     = 0;
        slave_wait   = 0;
        reset_n      = 1'b0;
        jdo          = '0;
        take_a       = 1'b0;
        take_b       = 1'b0;
        take_p       = 1'b0;

        // ---- reset state ----
        #2;
        check("rst_dreg", mon_dreg, 0);
        check("rst_ready", mon_ready, 0);
        check("rst_error", mon_error, 0);
        check("rst_read", avm_read, 0);
        check("rst_write", avm_write, 0);
        check("rst_be", avm_byteenable, 4'hF);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        base = req_cycles;
        repeat (100) @(negedge clk);
        check("idle_req_cycles", req_cycles - base, 0);
        check("idle_ready", mon_ready, 0);
        check("idle_be", avm_byteenable, 4'hF);

        // ---- a-phase read, best-case latency ----
        slave_wait   = 0;
        avm_readdata = 32'h1234_5678;
        exp_bus.push_back('{1'b0, 32'h100, 32'h0});
        exp_res.push_back(32'h1234_5678);
        drive(1'b1, 1'b0, 1'b0, jdo_a(30'h40, 1'b1, 1'b0));
        check("lat_read_n1", avm_read, 1);
        check("lat_addr_n1", avm_address, 32'h100);
        check("lat_ready_n1", mon_ready, 0);
        @(negedge clk);
        check("lat_ready_n2", mon_ready, 1);
        check("lat_dreg_n2", mon_dreg, 32'h1234_5678);
        check("lat_idle_n2", avm_read, 0);

        // b-read hits the same address: the a-read did not increment.
        avm_readdata = 32'h0BAD_F00D;
        exp_bus.push_back('{1'b0, 32'h100, 32'h0});
        exp_res.push_back(32'h0BAD_F00D);
        drive(1'b0, 1'b1, 1'b0, jdo_br());
        wait_ready("brd_ready", 20);

        // ---- b-writes across the top of the address space ----
        drive(1'b1, 1'b0, 1'b0, jdo_a(30'h3FFF_FFFE, 1'b0, 1'b0));
        slave_wait = 3;
        exp_bus.push_back('{1'b1, 32'hFFFF_FFF8, 32'hA});
        exp_bus.push_back('{1'b1, 32'hFFFF_FFFC, 32'hB});
        exp_bus.push_back('{1'b1, 32'h0000_0000, 32'hC});
        for (int i = 0; i < 3; i++) begin
            logic [31:0] d;
            d = 32'hA + 32'(i);
            exp_res.push_back(d);
            drive(1'b0, 1'b1, 1'b0, jdo_bw(d));
            wait_ready("wr_ready", 30);
        end
        check("wrap_error", mon_error, 0);
        slave_wait   = 0;
        avm_readdata = 32'h0000_0001;
        exp_bus.push_back('{1'b0, 32'h4, 32'h0});
        exp_res.push_back(32'h0000_0001);
        drive(1'b0, 1'b1, 1'b0, jdo_br());
        wait_ready("wrap_rd_ready", 20);

        // ---- timeout ----
        slave_wait = 1000;
        base       = req_cycles;
        exp_bus.push_back('{1'b0, 32'h80, 32'h0});
        exp_res.push_back(32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 1'b0, jdo_a(30'h20, 1'b1, 1'b0));
        wait_ready("to_ready", 40);
        check("to_req_cycles", req_cycles - base, TO_CYC);
        check("to_error", mon_error, 1);
        check("to_dreg", mon_dreg, 32'hDEAD_BEEF);
        check("to_read_low", avm_read, 0);
        if (exp_bus.size() != 0) void'(exp_bus.pop_front());
        slave_wait = 0;
        drive(1'b0, 1'b0, 1'b1, jdo_poll(1'b0));
        check("poll_noclr_error", mon_error, 1);
        drive(1'b0, 1'b0, 1'b1, jdo_poll(1'b1));
        check("poll_clr_error", mon_error, 0);
        avm_readdata = 32'h5555_AAAA;
        exp_bus.push_back('{1'b0, 32'h80, 32'h0});
        exp_res.push_back(32'h5555_AAAA);
        drive(1'b0, 1'b1, 1'b0, jdo_br());
        wait_ready("to_rd_ready", 20);

        // ---- b while busy: dropped, error wins over same-cycle clear ----
        slave_wait   = 5;
        avm_readdata = 32'hCAFE_0001;
        base         = n_xfers;
        exp_bus.push_back('{1'b0, 32'h180, 32'h0});
        exp_res.push_back(32'hCAFE_0001);
        drive(1'b1, 1'b0, 1'b0, jdo_a(30'h60, 1'b1, 1'b0));
        drive(1'b0, 1'b1, 1'b1, jdo_bw(32'hFFFF_FFFF));
        check("drop_error", mon_error, 1);
        wait_ready("drop_ready", 20);
        repeat (10) @(negedge clk);
        check("drop_xfers", n_xfers - base, 1);
        check("drop_error_sticky", mon_error, 1);
        drive(1'b0, 1'b0, 1'b1, jdo_poll(1'b1));
        check("drop_clr", mon_error, 0);

        // ---- simultaneous a and b in IDLE: only a runs ----
        slave_wait   = 2;
        avm_readdata = 32'h0000_BEEF;
        base         = n_xfers;
        exp_bus.push_back('{1'b0, 32'hC00, 32'h0});
        exp_res.push_back(32'h0000_BEEF);
        drive(1'b1, 1'b1, 1'b0, jdo_a(30'h300, 1'b1, 1'b0));
        wait_ready("both_ready", 20);
        repeat (5) @(negedge clk);
        check("both_xfers", n_xfers - base, 1);
        check("both_error", mon_error, 0);
        slave_wait   = 0;
        avm_readdata = 32'h1111_2222;
        exp_bus.push_back('{1'b0, 32'hC00, 32'h0});
        exp_res.push_back(32'h1111_2222);
        drive(1'b0, 1'b1, 1'b0, jdo_br());
        wait_ready("both_rd_ready", 20);

        // ---- error response, then clear through strobe a ----
        avm_response = 2'b10;
        avm_readdata = 32'h7777_8888;
        exp_bus.push_back('{1'b0, 32'h40, 32'h0});
        exp_res.push_back(32'h7777_8888);
        drive(1'b1, 1'b0, 1'b0, jdo_a(30'h10, 1'b1, 1'b0));
        wait_ready("resp_ready", 20);
        check("resp_error", mon_error, 1);
        avm_response = 2'b00;
        drive(1'b1, 1'b0, 1'b0, jdo_a(30'h10, 1'b0, 1'b1));
        check("a_clr_error", mon_error, 0);

        // ---- reset during a stalled write ----
        slave_wait = 1000;
        exp_bus.push_back('{1'b1, 32'h40, 32'h77});
        drive(1'b0, 1'b1, 1'b0, jdo_bw(32'h77));
        check("rst_mid_write_pre", avm_write, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_write_async", avm_write, 0);
        check("rst_mid_read_async", avm_read, 0);
        if (exp_bus.size() != 0) void'(exp_bus.pop_front());
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("rst2_ready", mon_ready, 0);
        check("rst2_error", mon_error, 0);
        check("rst2_dreg", mon_dreg, 0);
        slave_wait   = 0;
        avm_readdata = 32'h0F0F_0F0F;
        exp_bus.push_back('{1'b0, 32'h0, 32'h0});
        exp_res.push_back(32'h0F0F_0F0F);
        drive(1'b0, 1'b1, 1'b0, jdo_br());
        wait_ready("rst2_rd_ready", 20);

        repeat (5) @(negedge clk);
        check("bus_q_left", exp_bus.size(), 0);
        check("res_q_left", exp_res.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
